eth_transmitter_system: RTL



---
 rtl/eth_tx_pkg.sv | 19 +
 rtl/eth_tx_spi_shifter.sv | 61 ++++++
 rtl/eth_transmitter_system.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants and types for the memory-mapped Ethernet SPI transmitter.
`timescale 1ns/1ps
package eth_tx_pkg;

  localparam logic [15:0] TX_BUF_BASE    = 16'hE800;
  localparam logic [15:0] TX_CR_ADDR     = 16'hFB10;
  localparam logic [15:0] TX_LEN_LO_ADDR = 16'hFB12;
  localparam logic [15:0] TX_LEN_HI_ADDR = 16'hFB13;

  localparam int MIN_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } tx_state_e;

endpackage

// File: rtl/eth_tx_spi_shifter.sv
// SPI mode-0 byte shifter: sck divider, MSB-first shifting, byte reload on the 8th falling edge.
`timescale 1ns/1ps
module eth_tx_spi_shifter #(
  parameter int SCK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] data,
  output logic       sck,
  output logic       mosi,
  output logic       tick,
  output logic       byte_done
);

  localparam int            CW       = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;

  assign tick      = en && (div_cnt == DIV_LAST);
  assign byte_done = tick && sck && (bit_cnt == 4'd8);
  assign mosi      = shreg[7];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
    end else if (load) begin
      div_cnt <= '0;
      shreg   <= data;
      bit_cnt <= '0;
      sck     <= 1'b0;
    end else if (en) begin
      if (tick) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (!sck) begin
          bit_cnt <= bit_cnt + 1'b1;
        end else if (bit_cnt == 4'd8) begin
          // Falling edge after the 8th bit: next byte goes straight onto the wire.
          shreg   <= data;
          bit_cnt <= '0;
        end else begin
          shreg <= {shreg[6:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt <= '0;
    end
  end

endmodule

// File: rtl/eth_transmitter_system.sv
// CPU-bus Ethernet frame transmitter: 2 KiB buffer, LEN/CR registers, frame FSM, SPI master out.
// Build option: define ETH_TX_PAD_EN to zero-pad short frames (0<LEN<60) to 60 bytes on the wire.
`timescale 1ns/1ps
module eth_transmitter_system
  import eth_tx_pkg::*;
#(
  parameter int SCK_DIV   = 4,
  parameter int IFG_BYTES = 12,
  parameter int A_WIDTH   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_we,
  input  logic        n_oe,
  output logic        tx_sck,
  output logic        tx_mosi,
  output logic        n_tx_ss,
  output logic        n_irq
);

  localparam int            GAP_CLKS = IFG_BYTES * 16 * SCK_DIV;
  localparam int            GW       = $clog2(GAP_CLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  logic [7:0]         mem [2**A_WIDTH];
  tx_state_e          state_q, state_d;
  logic [A_WIDTH-1:0] len_q, eff_len, byte_cnt;
  logic [A_WIDTH:0]   src_idx;
  logic [15:0]        len_ext;
  logic [GW-1:0]      gap_cnt;
  logic               done_q, n_ss_q, busy;
  logic               sel_buf, sel_cr, sel_lo, sel_hi, wr, rd_en;
  logic               start_req, clr_req, last_byte, set_done;
  logic               load, en, tick, byte_done;
  logic [7:0]         sh_data, rd_data;

  assign sel_buf   = (a[15:11] == TX_BUF_BASE[15:11]);
  assign sel_cr    = (a == TX_CR_ADDR);
  assign sel_lo    = (a == TX_LEN_LO_ADDR);
  assign sel_hi    = (a == TX_LEN_HI_ADDR);
  assign wr        = !n_we;
  assign busy      = (state_q != IDLE);
  assign start_req = wr && sel_cr && d[0];
  assign clr_req   = wr && sel_cr && d[1];
  assign len_ext   = {{(16 - A_WIDTH){1'b0}}, len_q};

`ifdef ETH_TX_PAD_EN
  assign eff_len = (len_q != '0 && len_q < A_WIDTH'(MIN_FRAME_LEN)) ? A_WIDTH'(MIN_FRAME_LEN) : len_q;
`else
  assign eff_len = len_q;
`endif

  assign last_byte = (byte_cnt == eff_len - 1'b1);

  // Shifter source: byte 0 at start, otherwise the byte after the one on the wire; past LEN it is pad/idle zero.
  assign src_idx = (state_q == IDLE) ? '0 : {1'b0, byte_cnt} + 1'b1;
  assign sh_data = (src_idx < {1'b0, len_q}) ? mem[src_idx[A_WIDTH-1:0]] : 8'h00;
  assign en      = (state_q == SETUP) || (state_q == SHIFT);

  eth_tx_spi_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (en),
    .data      (sh_data),
    .sck       (tx_sck),
    .mosi      (tx_mosi),
    .tick      (tick),
    .byte_done (byte_done)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    set_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (eff_len != '0) begin
            state_d = SETUP;
            load    = 1'b1;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (byte_done && last_byte) state_d = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d  = IDLE;
          set_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_ss_q   <= 1'b1;
      done_q   <= 1'b0;
      len_q    <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      n_ss_q <= !((state_d == SETUP) || (state_d == SHIFT));
      // Setting wins, so a clear+start with LEN=0 still ends with done=1.
      if (set_done)     done_q <= 1'b1;
      else if (clr_req) done_q <= 1'b0;
      if (wr && !busy) begin
        if (sel_lo) len_q[7:0]         <= d;
        if (sel_hi) len_q[A_WIDTH-1:8] <= d[A_WIDTH-9:0];
      end
      if (load)           byte_cnt <= '0;
      else if (byte_done) byte_cnt <= byte_cnt + 1'b1;
      if (state_q != GAP) gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // NOTE: the frame buffer is deliberately not reset; it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr && sel_buf && !busy) mem[a[A_WIDTH-1:0]] <= d;
  end

  always_comb begin
    rd_data = 8'h00;
    if (sel_buf)     rd_data = busy ? 8'hFF : mem[a[A_WIDTH-1:0]];
    else if (sel_cr) rd_data = {6'b0, done_q, busy};
    else if (sel_lo) rd_data = len_ext[7:0];
    else if (sel_hi) rd_data = len_ext[15:8];
  end

  assign rd_en   = !n_oe && n_we && (sel_buf || sel_cr || sel_lo || sel_hi);
  assign d       = rd_en ? rd_data : 8'bz;
  assign n_tx_ss = n_ss_q;
  assign n_irq   = !done_q;

endmodule
